wta_tree_ctrl: RTL and testbench
================================

Name: wta_tree_ctrl

Overview:
- Sequencer for the winner-take-all disparity comparator tree (the stage-1 4:1 compare array plus its downstream reduction stages).
- Accepts one per-pixel cost vector per handshake for a configured frame (width x height).
- Drives the tree's common clock enable and input valid, and carries pixel coordinates / end-of-frame as sideband aligned to the tree output.
- Applies downstream backpressure by stalling the whole tree; signals busy/done around a frame.

Parameters:
STAGES, 4, number of registered comparator stages in the tree (input-to-winner latency in enabled cycles)
XW, 11, width of column counter / cfg_width
YW, 10, width of row counter / cfg_height

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  pulse; begin a frame (honoured only in IDLE)
cfg_width  in  XW  pixels per row, latched on accepted start
cfg_height  in  YW  rows per frame, latched on accepted start
in_valid  in  1  cost vector present on tree input bus
in_ready  out  1  controller accepts current vector
tree_clken  out  1  common clken to every tree stage
tree_valid  out  1  valid into tree stage 1
tree_rst_n  out  1  active-low reset to tree, equal to ~rst
out_valid  out  1  tree output holds a winner
out_ready  in  1  downstream accepts winner
out_x  out  XW  column of output winner
out_y  out  YW  row of output winner
out_last  out  1  output winner is last pixel of frame
busy  out  1  state is RUN or DRAIN
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset: state=IDLE; counters, latched config and sideband shift register cleared. in_ready=0, tree_valid=0, out_valid=0, out_x=0, out_y=0, out_last=0, busy=0, done=0; tree_clken=1.
- Stall rule (combinational): tree_clken = ~(out_valid & ~out_ready). When 0, the whole tree and sideband register hold.
- Acceptance: in_ready = (state==RUN) & tree_clken. accept = in_valid & in_ready. tree_valid = accept.
- Sideband register, depth STAGES, entry {v,x,y,last}:
  - On tree_clken: entry0 <= {accept, x_cnt, y_cnt, accept & is_last}; entry k <= entry k-1.
  - out_* are driven from entry STAGES-1.
- Latency: a vector accepted in cycle t appears on out_valid at t+STAGES when there are no stalls. Each stall cycle adds one.
- Counters: on accept, x_cnt increments. When x_cnt==W-1, x_cnt <= 0 and y_cnt increments. is_last = (x_cnt==W-1) & (y_cnt==H-1).
- FSM:
  - IDLE: start & cfg_width!=0 & cfg_height!=0 -> latch W,H, clear counters, go to RUN. A start with a zero dimension is ignored (stays IDLE, no done).
  - RUN: accept & is_last -> DRAIN.
  - DRAIN: in_ready=0. When out_valid & out_ready & out_last -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- start while not in IDLE is ignored. cfg_* changes after latch have no effect.
- Bubbles: tree_valid=0 cycles propagate as out_valid=0. The tree is not compacted.
- Simultaneous events:
  - Last-pixel accept and stall in the same cycle: accept is impossible, since in_ready=0.
  - out_last handshake and start in the same cycle: start ignored; it is honoured no earlier than the cycle after DONE.
- W=1, H=1: single accept moves RUN->DRAIN; done arrives STAGES+1 cycles after accept with out_ready=1.
- Reset mid-frame: everything returns to reset values next edge. tree_rst_n drives low while rst=1 so tree en flops clear. No done pulse is produced.
- Widths: counters compare against latched W-1 and H-1, computed once at latch (XW/YW bits, no overflow since W,H >= 1).

Decomposition:
- Shared package: state encoding (IDLE, RUN, DRAIN, DONE) and the sideband entry struct {v, x, y, last}; STAGES default constant shared with the tree top.
- One natural sub-module, wta_sideband_pipe: STAGES-deep enabled shift register for sideband entries, with sync clear.

Test Plan:
- W=4,H=2, in_valid=1, out_ready=1 constant, STAGES=4 -> 8 accepts in consecutive cycles; out_valid high for 8 cycles starting 4 cycles after the first accept; (x,y) = (0,0)..(3,0),(0,1)..(3,1); out_last only on (3,1); done one cycle after it; busy low afterwards.
- Same frame, out_ready held 0 for 3 cycles once out_valid rises -> tree_clken=0 and in_ready=0 for exactly those 3 cycles; no output lost or duplicated; total done delay +3.
- in_valid toggling 1,0,1,0 -> tree_valid bubbles reappear 4 cycles later as out_valid gaps; coordinates still contiguous 0,1,2,3.
- start with cfg_width=0 -> stays IDLE, busy=0, no done. Then start with W=1,H=1 -> one accept, out_last=1 at +4, done at +5.
- rst asserted for one cycle while in RUN after 3 accepts -> next cycle: out_valid=0, busy=0, in_ready=0, tree_rst_n was 0 during rst, no done. New start then produces (0,0) first.
- start pulsed during DRAIN -> ignored; done occurs once; second start after DONE runs a full frame.

Source files
------------

// File: rtl/wta_tree_ctrl_pkg.sv
// wta_tree_ctrl_pkg: shared state encoding, defaults and sideband entry type for the WTA tree sequencer.
package wta_tree_ctrl_pkg;
  localparam int STAGES_DEF = 4;
  localparam int XW_DEF = 11;
  localparam int YW_DEF = 10;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  typedef struct packed {
    logic v;
    logic [XW_DEF-1:0] x;
    logic [YW_DEF-1:0] y;
    logic last;
  } sb_entry_t;
endpackage

// File: rtl/wta_sideband_pipe.sv
// wta_sideband_pipe: enabled shift register carrying sideband alongside the comparator tree.
module wta_sideband_pipe #(
  parameter int DEPTH = 4,
  parameter int DW = 23
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  input  logic [DW-1:0] i_d,
  output logic [DW-1:0] o_q
);
  logic [DW-1:0] r_q [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_q[k] <= '0;
    end else if (i_en) begin
      r_q[0] <= i_d;
      for (int k = 1; k < DEPTH; k++) r_q[k] <= r_q[k-1];
    end
  end
  assign o_q = r_q[DEPTH-1];
endmodule

// File: rtl/wta_tree_ctrl.sv
// wta_tree_ctrl: sequences a frame of cost vectors through the WTA tree with stall and coordinate sideband.
module wta_tree_ctrl
  import wta_tree_ctrl_pkg::*;
#(
  parameter int STAGES = STAGES_DEF,
  parameter int XW = XW_DEF,
  parameter int YW = YW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] cfg_width,
  input  logic [YW-1:0] cfg_height,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          tree_clken,
  output logic          tree_valid,
  output logic          tree_rst_n,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          out_last,
  output logic          busy,
  output logic          done
);
  localparam int DW = XW + YW + 2;
  logic [1:0] r_state, w_nxt;
  logic [XW-1:0] r_x, r_wm1;
  logic [YW-1:0] r_y, r_hm1;
  logic w_go, w_acc, w_x_wrap, w_is_last, w_hs_last;
  logic [DW-1:0] w_q;
  assign tree_clken = ~(out_valid & ~out_ready);
  assign in_ready = (r_state == S_RUN) & tree_clken;
  assign w_acc = in_valid & in_ready;
  assign tree_valid = w_acc;
  assign tree_rst_n = ~rst;
  assign w_go = start & (cfg_width != '0) & (cfg_height != '0);
  assign w_x_wrap = r_x == r_wm1;
  assign w_is_last = w_x_wrap & (r_y == r_hm1);
  assign w_hs_last = out_valid & out_ready & out_last;
  assign busy = (r_state == S_RUN) | (r_state == S_DRAIN);
  assign done = r_state == S_DONE;
  always_comb begin
    w_nxt = r_state == S_IDLE  ? (w_go ? S_RUN : S_IDLE) :
            r_state == S_RUN   ? (w_acc & w_is_last ? S_DRAIN : S_RUN) :
            r_state == S_DRAIN ? (w_hs_last ? S_DONE : S_DRAIN) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x <= '0;
      r_y <= '0;
      r_wm1 <= '0;
      r_hm1 <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == S_IDLE && w_go) begin
        r_wm1 <= cfg_width - 1'b1;
        r_hm1 <= cfg_height - 1'b1;
        r_x <= '0;
        r_y <= '0;
      end else if (w_acc) begin
        r_x <= w_x_wrap ? '0 : r_x + 1'b1;
        r_y <= w_x_wrap ? r_y + 1'b1 : r_y;
      end
    end
  end
  // Entry travels with its vector; a bubble carries v=0 so the tree is never compacted.
  wta_sideband_pipe #(.DEPTH(STAGES), .DW(DW)) u_pipe (
    .clk  (clk),
    .rst  (rst),
    .i_en (tree_clken),
    .i_d  ({w_acc, r_x, r_y, w_acc & w_is_last}),
    .o_q  (w_q)
  );
  assign {out_valid, out_x, out_y, out_last} = w_q;
endmodule

// File: tb/tb_wta_tree_ctrl.sv
// tb_wta_tree_ctrl: frame-level model with per-cycle compare plus directed literal checks.
module tb_wta_tree_ctrl;
  localparam int STAGES = 4, XW = 11, YW = 10;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 1;
  logic [XW-1:0] cfg_width = '0;
  logic [YW-1:0] cfg_height = '0;
  logic in_ready, tree_clken, tree_valid, tree_rst_n, out_valid, out_last, busy, done;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;

  wta_tree_ctrl #(.STAGES(STAGES), .XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .in_valid(in_valid), .in_ready(in_ready), .tree_clken(tree_clken), .tree_valid(tree_valid),
    .tree_rst_n(tree_rst_n), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_y(out_y), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0, stall_cnt = 0;
  bit armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: each accepted pixel gets its raster coordinates from its index and the
  // count of enabled cycles at acceptance; it must emerge STAGES enabled cycles later.
  typedef struct {int e; int x; int y; bit last;} item_t;
  typedef struct {int x; int y; bit last; int cyc;} rec_t;
  item_t q[$];
  rec_t log_q[$];
  int acc_cyc[$], done_cyc[$];
  int m_phase = 0, m_w = 0, m_h = 0, m_idx = 0, en_cnt = 0;

  always @(negedge clk) begin : model
    bit ov, ce, ir, acc, hs;
    if (armed) begin
      cyc++;
      ov = q.size() > 0 && q[0].e + STAGES == en_cnt;
      ce = !(ov && !out_ready);
      ir = m_phase == 1 && ce;
      acc = in_valid && ir;
      chk("out_valid", 32'(out_valid), 32'(ov));
      chk("tree_clken", 32'(tree_clken), 32'(ce));
      chk("in_ready", 32'(in_ready), 32'(ir));
      chk("tree_valid", 32'(tree_valid), 32'(acc));
      chk("busy", 32'(busy), 32'(m_phase == 1 || m_phase == 2));
      chk("done", 32'(done), 32'(m_phase == 3));
      chk("tree_rst_n", 32'(tree_rst_n), 32'(!rst));
      chk("out_last", 32'(out_last), 32'(ov ? q[0].last : 1'b0));
      if (ov) begin
        chk("out_x", 32'(out_x), 32'(q[0].x));
        chk("out_y", 32'(out_y), 32'(q[0].y));
      end
      if (out_valid && out_ready) log_q.push_back('{int'(out_x), int'(out_y), out_last, cyc});
      if (tree_valid) acc_cyc.push_back(cyc);
      if (done) done_cyc.push_back(cyc);
      if (!tree_clken) stall_cnt++;
      if (rst) begin
        q.delete();
        m_phase = 0;
      end else begin
        hs = ov && out_ready && q[0].last;
        if (ov && out_ready) void'(q.pop_front());
        if (acc) begin
          q.push_back('{en_cnt, m_idx % m_w, m_idx / m_w, m_idx == m_w * m_h - 1});
          m_idx++;
        end
        case (m_phase)
          0: if (start && cfg_width != 0 && cfg_height != 0) begin
               m_w = int'(cfg_width);
               m_h = int'(cfg_height);
               m_idx = 0;
               m_phase = 1;
             end
          1: if (acc && m_idx == m_w * m_h) m_phase = 2;
          2: if (hs) m_phase = 3;
          default: m_phase = 0;
        endcase
      end
      if (ce) en_cnt++;
    end
  end

  task automatic run_frame(input logic [XW-1:0] w, input logic [YW-1:0] h);
    cfg_width = w;
    cfg_height = h;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cyc.size() == base && n < 300) begin
      tick();
      n++;
    end
    chk("done_seen", 32'(done_cyc.size() > base), 32'd1);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int xs[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int ys[8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    int d0, l0, a0, s0, n;
    repeat (2) tick();
    rst = 0;
    armed = 1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_clken", 32'(tree_clken), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_out_x", 32'(out_x), 32'd0);
    tick();

    // Frame 4x2, free-flowing
    in_valid = 1;
    d0 = done_cyc.size(); l0 = log_q.size(); a0 = acc_cyc.size();
    run_frame(4, 2);
    wait_done(d0);
    chk("t1_count", 32'(log_q.size() - l0), 32'd8);
    if (log_q.size() - l0 == 8 && done_cyc.size() > d0) begin
      for (int i = 0; i < 8; i++) begin
        chk("t1_x", 32'(log_q[l0+i].x), 32'(xs[i]));
        chk("t1_y", 32'(log_q[l0+i].y), 32'(ys[i]));
      end
      chk("t1_last7", 32'(log_q[l0+7].last), 32'd1);
      chk("t1_last6", 32'(log_q[l0+6].last), 32'd0);
      chk("t1_latency", 32'(log_q[l0].cyc - acc_cyc[a0]), 32'd4);
      chk("t1_done_after_last", 32'(done_cyc[d0] - log_q[l0+7].cyc), 32'd1);
      chk("t1_total", 32'(done_cyc[d0] - acc_cyc[a0]), 32'd12);
    end
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Same frame with a 3-cycle downstream stall
    d0 = done_cyc.size(); l0 = log_q.size(); a0 = acc_cyc.size(); s0 = stall_cnt;
    run_frame(4, 2);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
    out_ready = 0;
    repeat (3) tick();
    out_ready = 1;
    wait_done(d0);
    chk("t2_stalls", 32'(stall_cnt - s0), 32'd3);
    chk("t2_count", 32'(log_q.size() - l0), 32'd8);
    if (done_cyc.size() > d0) chk("t2_total", 32'(done_cyc[d0] - acc_cyc[a0]), 32'd15);

    // Bubbles: in_valid toggling
    in_valid = 0;
    d0 = done_cyc.size(); l0 = log_q.size();
    run_frame(4, 1);
    n = 0;
    while (done_cyc.size() == d0 && n < 100) begin
      in_valid = ~in_valid;
      tick();
      n++;
    end
    in_valid = 1;
    wait_done(d0 - 1);
    chk("t3_count", 32'(log_q.size() - l0), 32'd4);
    if (log_q.size() - l0 == 4)
      for (int i = 0; i < 3; i++) begin
        chk("t3_x", 32'(log_q[l0+i+1].x), 32'(i + 1));
        chk("t3_gap", 32'(log_q[l0+i+1].cyc - log_q[l0+i].cyc), 32'd2);
      end

    // Zero-width start ignored, then 1x1
    d0 = done_cyc.size();
    run_frame(0, 2);
    repeat (5) tick();
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_no_done", 32'(done_cyc.size()), 32'(d0));
    l0 = log_q.size(); a0 = acc_cyc.size();
    run_frame(1, 1);
    wait_done(d0);
    chk("t4_count", 32'(log_q.size() - l0), 32'd1);
    if (log_q.size() > l0 && done_cyc.size() > d0) begin
      chk("t4_last", 32'(log_q[l0].last), 32'd1);
      chk("t4_out_delay", 32'(log_q[l0].cyc - acc_cyc[a0]), 32'd4);
      chk("t4_done_delay", 32'(done_cyc[d0] - acc_cyc[a0]), 32'd5);
    end

    // Reset mid-frame after 3 accepts
    a0 = acc_cyc.size();
    run_frame(4, 2);
    repeat (3) tick();
    chk("t5_accepts", 32'(acc_cyc.size() - a0), 32'd3);
    rst = 1;
    @(negedge clk);
    chk("t5_tree_rst_n", 32'(tree_rst_n), 32'd0);
    tick();
    rst = 0;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd0);
    d0 = done_cyc.size();
    repeat (8) tick();
    chk("t5_no_done", 32'(done_cyc.size()), 32'(d0));
    l0 = log_q.size();
    run_frame(4, 2);
    wait_done(d0);
    chk("t5_count", 32'(log_q.size() - l0), 32'd8);
    if (log_q.size() > l0) begin
      chk("t5_first_x", 32'(log_q[l0].x), 32'd0);
      chk("t5_first_y", 32'(log_q[l0].y), 32'd0);
    end

    // Start during DRAIN is ignored
    d0 = done_cyc.size();
    run_frame(2, 1);
    repeat (2) tick();
    run_frame(4, 2);
    wait_done(d0);
    repeat (10) tick();
    chk("t6_single_done", 32'(done_cyc.size() - d0), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    l0 = log_q.size();
    d0 = done_cyc.size();
    run_frame(4, 2);
    wait_done(d0);
    chk("t6_second_count", 32'(log_q.size() - l0), 32'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
